// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-cycle controller that decodes MOV/ALU instructions and
//            sequences register file, A/B/C/status loads, shifter and ALU.
// Revision : 1.0  initial release
// ============================================================================
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        done,
    output logic        err,
    output logic [2:0]  nsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        vsel,
    output logic        write,
    output logic [1:0]  alu_op,
    output logic [1:0]  shift,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;

    logic [2:0]  w_opc;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    logic        w_is_movi;
    logic        w_is_movr;
    logic        w_is_alu;
    logic        w_is_cmp;
    logic        w_is_mvn;
    logic        w_legal;

    assign w_opc     = r_ir[15:13];
    assign w_op      = r_ir[12:11];
    assign w_rn      = r_ir[10:8];
    assign w_rd      = r_ir[7:5];
    assign w_sh      = r_ir[4:3];
    assign w_rm      = r_ir[2:0];
    assign w_is_movi = (w_opc == 3'b110) && (w_op == 2'b10);
    assign w_is_movr = (w_opc == 3'b110) && (w_op == 2'b00);
    assign w_is_alu  = (w_opc == 3'b101);
    assign w_is_cmp  = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
    assign w_legal   = w_is_movi || w_is_movr || w_is_alu;

    assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next;
            if ((r_state == S_WAIT) && in_valid) begin
                r_ir <= in_instr;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        nsel     = 3'd0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        vsel     = 1'b0;
        write    = 1'b0;
        alu_op   = 2'b00;
        shift    = 2'b00;
        case (r_state)
            S_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    done   = 1'b1;
                    err    = 1'b1;
                    w_next = S_WAIT;
                end else if (w_is_movi) begin
                    w_next = S_WRITE_IMM;
                end else if (w_is_movr || w_is_mvn) begin
                    w_next = S_GET_B;
                end else begin
                    w_next = S_GET_A;
                end
            end
            S_GET_A: begin
                nsel   = w_rn;
                loada  = 1'b1;
                w_next = S_GET_B;
            end
            S_GET_B: begin
                nsel   = w_rm;
                loadb  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                shift = w_sh;
                if (w_is_cmp) begin
                    alu_op = 2'b01;
                    loads  = 1'b1;
                    done   = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    // MOV reg passes B through as 0 + B
                    alu_op = w_is_movr ? 2'b00 : w_op;
                    asel   = w_is_movr;
                    loadc  = 1'b1;
                    w_next = S_WRITE_REG;
                end
            end
            S_WRITE_REG: begin
                nsel   = w_rd;
                write  = 1'b1;
                done   = 1'b1;
                w_next = S_WAIT;
            end
            S_WRITE_IMM: begin
                nsel   = w_rn;
                vsel   = 1'b1;
                write  = 1'b1;
                done   = 1'b1;
                w_next = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed plus random instruction sequences for alu_sequencer,
//            compared cycle by cycle against a per-instruction step recipe.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready, done, err;
    logic [2:0]  nsel;
    logic        loada, loadb, loadc, loads, asel, vsel, write;
    logic [1:0]  alu_op, shift;
    logic [15:0] sximm8;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev_ir = 16'h0000;
    logic [32:0] expq[$];
    logic [32:0] w_obs;

    alu_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .done     (done),
        .err      (err),
        .nsel     (nsel),
        .loada    (loada),
        .loadb    (loadb),
        .loadc    (loadc),
        .loads    (loads),
        .asel     (asel),
        .vsel     (vsel),
        .write    (write),
        .alu_op   (alu_op),
        .shift    (shift),
        .sximm8   (sximm8)
    );

    always #5 clk = ~clk;

    assign w_obs = {in_ready, done, err, nsel, loada, loadb, loadc, loads,
                    asel, vsel, write, alu_op, shift, sximm8};

    function automatic logic [15:0] sx(input logic [15:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

    function automatic logic [32:0] vec(
        input logic rdy, input logic dn, input logic er, input logic [2:0] ns,
        input logic la, input logic lb, input logic lc, input logic ls,
        input logic as, input logic vs, input logic wr,
        input logic [1:0] aop, input logic [1:0] sh, input logic [15:0] sxv);
        return {rdy, dn, er, ns, la, lb, lc, ls, as, vs, wr, aop, sh, sxv};
    endfunction

    function automatic logic [32:0] idle(input logic [15:0] ir);
        return vec(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, sx(ir));
    endfunction

    // Expected per-cycle outputs after acceptance, straight from the instruction classes
    task automatic build(input logic [15:0] ins);
        logic [2:0]  opc = ins[15:13];
        logic [1:0]  op  = ins[12:11];
        logic [2:0]  rn  = ins[10:8];
        logic [2:0]  rd  = ins[7:5];
        logic [1:0]  sh  = ins[4:3];
        logic [2:0]  rm  = ins[2:0];
        logic [15:0] s   = sx(ins);
        bit movi  = (opc == 3'd6) && (op == 2'd2);
        bit movr  = (opc == 3'd6) && (op == 2'd0);
        bit alu   = (opc == 3'd5);
        bit legal = movi || movr || alu;
        expq.delete();
        expq.push_back(vec(0, !legal, !legal, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, s));
        if (!legal) return;
        if (movi) begin
            expq.push_back(vec(0, 1, 0, rn, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, s));
            return;
        end
        if (alu && op != 2'd3)
            expq.push_back(vec(0, 0, 0, rn, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, s));
        expq.push_back(vec(0, 0, 0, rm, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, s));
        if (alu && op == 2'd1) begin
            expq.push_back(vec(0, 1, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b01, sh, s));
        end else begin
            expq.push_back(vec(0, 0, 0, 3'd0, 0, 0, 1, 0, movr, 0, 0,
                               movr ? 2'b00 : op, sh, s));
            expq.push_back(vec(0, 1, 0, rd, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, s));
        end
    endtask

    task automatic check(input string tag, input logic [32:0] exp);
        checks++;
        assert (w_obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, input bit hold, input int abort_at);
        build(ins);
        @(negedge clk);
        check($sformatf("wait before %h", ins), idle(prev_ir));
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk);
        #1;
        prev_ir = ins;
        for (int i = 0; i < expq.size(); i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            in_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            in_instr = 16'($urandom);
            check($sformatf("instr %h cycle %0d", ins, i + 1), expq[i]);
            if (i == abort_at) begin
                #2 reset = 1'b1;
                #1 check("async reset", idle(16'h0000));
                prev_ir = 16'h0000;
                @(posedge clk);
                #1 check("held reset", idle(16'h0000));
                @(negedge clk);
                reset    = 1'b0;
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("ready after %h", ins), idle(ins));
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_instr = 16'($urandom);
            check("idle", idle(prev_ir));
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        #1 check("reset state", idle(16'h0000));
        @(negedge clk);
        reset = 1'b0;

        run_instr(16'hD3FE, 1'b0, -1);   // MOV R3,#-2
        run_instr(16'hA140, 1'b0, -1);   // ADD R2,R1,R0
        run_instr(16'hAC0D, 1'b0, -1);   // CMP R4,R5 lsl-style sh=01
        run_instr(16'hC0C7, 1'b0, -1);   // MOV R6,R7
        run_instr(16'hB8C7, 1'b0, -1);   // MVN R6,R7
        run_instr(16'hE000, 1'b1, -1);   // illegal, valid held high
        run_instr(16'hD305, 1'b1, -1);
        idle_cycles(3);
        run_instr(16'hA140, 1'b0, 2);    // reset while in GET_B
        run_instr(16'hD405, 1'b0, -1);   // MOV R4,#5

        for (int k = 0; k < 40; k++) begin
            logic [2:0]  opc;
            logic [15:0] ins;
            case ($urandom_range(0, 3))
                0:       opc = 3'b110;
                1:       opc = 3'b101;
                default: opc = 3'($urandom);
            endcase
            ins = {opc, 13'($urandom)};
            run_instr(ins, 1'($urandom_range(0, 1)), -1);
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
